frame_store_writer: RTL

// Write-back counterpart of the frame-memory fetch path. Accepts per-colour 32-bit words on three
//   rts/rtr channels in strict R->G->B rotation and buffers them in a small FIFO. Drains the FIFO
//   as a linear write stream into frame memory with a wrapping address.

---
 rtl/frame_store_writer.sv | 94 +++++++++
 1 files changed

// File: rtl/frame_store_writer.sv
// frame_store_writer: R->G->B word collector feeding a 4-deep FIFO that drains to frame memory at a wrapping address.
// Optional `WB_FRAME_CNT_EN adds a 16-bit frame counter output.
module frame_store_writer #(
  parameter int NUM_ADDRS  = 115200,
  parameter int ADDR_W     = 17,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              en,
  input  logic [31:0]       r_data,
  input  logic              r_rts,
  output logic              r_rtr,
  input  logic [31:0]       g_data,
  input  logic              g_rts,
  output logic              g_rtr,
  input  logic [31:0]       b_data,
  input  logic              b_rts,
  output logic              b_rtr,
  output logic [31:0]       mem_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rts,
  input  logic              mem_rtr,
`ifdef WB_FRAME_CNT_EN
  output logic [15:0]       frame_cnt,
`endif
  output logic              frame_done
);
  localparam int DEPTH = 2 ** DEPTH_LOG2;
  typedef enum logic [2:0] {S_R = 3'b001, S_G = 3'b010, S_B = 3'b100} state_t;
  state_t              r_state, w_state_nxt;
  logic [DEPTH_LOG2:0] r_wr_ptr, r_rd_ptr;
  logic [31:0]         r_fifo [DEPTH];
  logic [ADDR_W-1:0]   r_addr;
  logic                r_done;
  logic                w_full, w_empty, w_push, w_pop, w_last;
  logic [31:0]         w_push_data;
`ifdef WB_FRAME_CNT_EN
  logic [15:0]         r_frame_cnt;
  assign frame_cnt = r_frame_cnt;
`endif
  assign w_empty    = r_wr_ptr == r_rd_ptr;
  assign w_full     = (r_wr_ptr[DEPTH_LOG2-1:0] == r_rd_ptr[DEPTH_LOG2-1:0]) &&
                      (r_wr_ptr[DEPTH_LOG2] != r_rd_ptr[DEPTH_LOG2]);
  assign w_pop      = ~w_empty & mem_rtr;
  assign w_last     = r_addr == ADDR_W'(NUM_ADDRS - 1);
  assign mem_data   = r_fifo[r_rd_ptr[DEPTH_LOG2-1:0]];
  assign mem_rts    = ~w_empty;
  assign mem_addr   = r_addr;
  assign frame_done = r_done;
  // Acceptance looks at full only, so a same-cycle pop never frees a slot early.
  always_comb begin
    r_rtr       = r_state[0] & ~w_full;
    g_rtr       = r_state[1] & ~w_full;
    b_rtr       = r_state[2] & ~w_full;
    w_push      = (r_rts & r_rtr) | (g_rts & g_rtr) | (b_rts & b_rtr);
    w_push_data = r_state[0] ? r_data : r_state[1] ? g_data : b_data;
    w_state_nxt = en ? S_R : w_push ? state_t'({r_state[1:0], r_state[2]}) : r_state;
  end
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) r_state <= S_R;
    else       r_state <= w_state_nxt;
  end
  always_ff @(posedge clk) begin
    if (w_push && !en) r_fifo[r_wr_ptr[DEPTH_LOG2-1:0]] <= w_push_data;
  end
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_addr   <= '0;
      r_done   <= 1'b0;
    end else if (en) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_addr   <= '0;
      r_done   <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_addr   <= w_last ? '0 : r_addr + 1'b1;
      end
      r_done <= w_pop & w_last;
    end
  end
`ifdef WB_FRAME_CNT_EN
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_)                 r_frame_cnt <= '0;
    else if (en)               r_frame_cnt <= '0;
    else if (w_pop && w_last)  r_frame_cnt <= r_frame_cnt + 1'b1;
  end
`endif
endmodule
